conv_output_writer: RTL and testbench
=====================================

Name: conv_output_writer

Overview:
- Downstream stage of the convolution top: captures each finished output-pixel vector (Piy*Pix lanes of RES bits), buffers it and writes it word-by-word to the output BRAM port.
- Generates the sequential BRAM write address, signals tile completion and applies back-pressure to the convolution engine when its buffer is full.
- Optional per-lane ReLU is applied before buffering.

Parameters:
- RES, 16, bits per pixel lane (signed two's complement)
- LANES, 8, pixel lanes per vector (Piy*Pix); vector width is LANES*RES = 128
- DEPTH, 4, buffer entries (power of two, >=2)
- ADDR_STEP, 4, byte increment per BRAM word written
- LAST_ADDR, 32'h1ffc, address of the final word of a tile

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  output vector present this cycle (the conv top's valid)
- in_pixels  input  LANES*RES  output vector; lane k at bits [(k+1)*RES-1 : k*RES]
- in_ready  output  1  buffer can accept a vector this cycle
- bram_busy  input  1  BRAM port unavailable this cycle; stalls writes
- write_en  output  1  BRAM write strobe
- bram_wr_addr  output  32  BRAM byte address of the current write
- output_pixels  output  LANES*RES  BRAM write data
- tile_done  output  1  one-cycle pulse on the write to LAST_ADDR
- overflow  output  1  sticky: in_valid arrived while in_ready was low
- fill_level  output  $clog2(DEPTH)+1  current buffer occupancy

Behaviour:
- Reset (async, rst_n low): in_ready=1, write_en=0, bram_wr_addr=0, output_pixels=0, tile_done=0, overflow=0, fill_level=0, FSM=IDLE, FIFO pointers=0. Reset mid-write discards all buffered data and any partial tile. The address restarts at 0.
- Accept: push when in_valid && in_ready. in_ready = (fill_level != DEPTH), combinational from registered count.
- Drop: in_valid && !in_ready drops the vector and sets overflow. overflow is cleared only by reset.
- Lane processing: applied on the push path, combinational, before storage.
- FIFO: circular, read/write pointers wrap modulo DEPTH. A simultaneous push and pop when full is legal only if the pop frees space that cycle. in_ready reflects the pre-pop count, so no push is accepted when full. A simultaneous push and pop keeps fill_level unchanged.
- FSM states IDLE, WRITE, TILE_END:
  - IDLE: write_en=0. Go to WRITE when fill_level != 0.
  - WRITE: on each cycle with fill_level != 0 and !bram_busy, pop one entry and register it: output_pixels <= entry, write_en <= 1, and the address register is updated.
    - The first write after reset or a tile end uses address 0. Each following write uses the previous address + ADDR_STEP.
    - If bram_busy or the FIFO is empty, write_en <= 0 and output_pixels and bram_wr_addr hold.
    - When empty and no write is issued, return to IDLE.
  - TILE_END: entered when a write is issued with address LAST_ADDR. tile_done=1 for exactly that write cycle. The next write address wraps to 0. State returns to WRITE or IDLE the next cycle depending on fill_level. No write is issued in TILE_END; this is a mandatory one-cycle bubble.
- Latency: a vector accepted at edge N into an empty buffer appears on write_en/output_pixels/bram_wr_addr after edge N+2 (IDLE->WRITE at N+1, registered write at N+2). With a non-empty buffer and no stall, throughput is 1 word/cycle except for the TILE_END bubble.
- Address arithmetic is 32-bit unsigned. Addresses past LAST_ADDR never occur because of the wrap.
- bram_busy only delays writes. It never drops or reorders data.

Optional Feature:
- Macro: CONV_OUTPUT_WRITER_RELU_EN.
- Defined: each lane whose MSB is 1 (negative) is replaced by 0 before storage; non-negative lanes pass unchanged.
- Undefined: lanes are stored bit-exact. No other behaviour differs.

Test Plan:
- Reset release, single vector 128'h0001_0002_..._0008 with in_valid for 1 cycle -> write_en high exactly 1 cycle, 2 cycles after acceptance, addr 0, data equal to input, fill_level returns to 0.
- 6 back-to-back vectors, DEPTH=4, bram_busy=1 for 10 cycles -> in_ready falls after 4 accepted, 5th and 6th dropped, overflow=1. After busy is released, 4 writes at addrs 0,4,8,12 in order.
- Continuous stream of 2049 vectors, no stall -> tile_done pulses on the write to 32'h1ffc. One bubble cycle follows, then the 2049th vector is written to addr 0.
- Alternating bram_busy every cycle with a steady stream -> no data loss, addresses strictly +4, write_en never high while bram_busy was high at the preceding edge.
- Assert rst_n low with 3 entries buffered and addr 32'h100 -> all outputs at reset values immediately. The next vector after release is written to addr 0.
- With CONV_OUTPUT_WRITER_RELU_EN, lane values 16'hFFFF, 16'h8000, 16'h7FFF -> written as 0, 0, 16'h7FFF. Without the macro -> written unchanged.

Source files
------------

// File: rtl/conv_output_writer.sv
// ============================================================================
// Module   : conv_output_writer
// Purpose  : Buffers finished conv output vectors and streams them to the
//            output BRAM with sequential addressing, tile-end signalling and
//            back-pressure. Optional ReLU: CONV_OUTPUT_WRITER_RELU_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_output_writer #(
    parameter int          RES       = 16,
    parameter int          LANES     = 8,
    parameter int          DEPTH     = 4,
    parameter int          ADDR_STEP = 4,
    parameter logic [31:0] LAST_ADDR = 32'h1ffc
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [LANES*RES-1:0]       in_pixels,
    output logic                       in_ready,
    input  logic                       bram_busy,
    output logic                       write_en,
    output logic [31:0]                bram_wr_addr,
    output logic [LANES*RES-1:0]       output_pixels,
    output logic                       tile_done,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fill_level
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam int C_VEC_W = LANES * RES;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        TILE_END = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [C_VEC_W-1:0]   mem_q [DEPTH];
    logic [C_VEC_W-1:0]   mem_d [DEPTH];
    logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [C_CNT_W-1:0]   count_q, count_d;
    logic                 write_en_q, write_en_d;
    logic                 tile_done_q, tile_done_d;
    logic                 overflow_q, overflow_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          next_addr_q, next_addr_d;
    logic [C_VEC_W-1:0]   out_q, out_d;

    logic                 w_push;
    logic                 w_pop;
    logic [C_VEC_W-1:0]   w_push_data;

    assign in_ready      = (count_q != C_CNT_W'(DEPTH));
    assign w_push        = in_valid && in_ready;
    assign write_en      = write_en_q;
    assign tile_done     = tile_done_q;
    assign overflow      = overflow_q;
    assign bram_wr_addr  = addr_q;
    assign output_pixels = out_q;
    assign fill_level    = count_q;

    always_comb begin
        w_push_data = in_pixels;
`ifdef CONV_OUTPUT_WRITER_RELU_EN
        for (int k = 0; k < LANES; k++) begin
            if (in_pixels[(k+1)*RES-1]) begin
                w_push_data[k*RES +: RES] = '0;
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        write_en_d  = 1'b0;
        tile_done_d = 1'b0;
        out_d       = out_q;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        mem_d       = mem_q;
        overflow_d  = overflow_q | (in_valid & ~in_ready);
        w_pop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = WRITE;
            end
            WRITE: begin
                if ((count_q != '0) && !bram_busy) begin
                    w_pop      = 1'b1;
                    write_en_d = 1'b1;
                    out_d      = mem_q[rd_ptr_q];
                    addr_d     = next_addr_q;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    // Writing the last word of a tile forces a one-cycle bubble.
                    if (next_addr_q == LAST_ADDR) begin
                        tile_done_d = 1'b1;
                        next_addr_d = 32'd0;
                        state_d     = TILE_END;
                    end else begin
                        next_addr_d = next_addr_q + 32'(ADDR_STEP);
                    end
                end else if (count_q == '0) begin
                    state_d = IDLE;
                end
            end
            TILE_END: begin
                state_d = (count_q != '0) ? WRITE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (w_push) begin
            mem_d[wr_ptr_q] = w_push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            write_en_q  <= 1'b0;
            tile_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            addr_q      <= 32'd0;
            next_addr_q <= 32'd0;
            out_q       <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            write_en_q  <= write_en_d;
            tile_done_q <= tile_done_d;
            overflow_q  <= overflow_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            out_q       <= out_d;
            mem_q       <= mem_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_output_writer.sv
// ============================================================================
// Module   : tb_conv_output_writer
// Purpose  : Scoreboard bench for conv_output_writer (directed sequence).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_output_writer;

    localparam int          LANES = 8;
    localparam int          VW    = 128;
    localparam logic [31:0] LAST  = 32'h1ffc;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            bram_busy = 1'b0;
    logic [VW-1:0]   in_pixels = '0;
    logic            in_ready;
    logic            write_en;
    logic [31:0]     bram_wr_addr;
    logic [VW-1:0]   output_pixels;
    logic            tile_done;
    logic            overflow;
    logic [2:0]      fill_level;

    conv_output_writer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_pixels     (in_pixels),
        .in_ready      (in_ready),
        .bram_busy     (bram_busy),
        .write_en      (write_en),
        .bram_wr_addr  (bram_wr_addr),
        .output_pixels (output_pixels),
        .tile_done     (tile_done),
        .overflow      (overflow),
        .fill_level    (fill_level)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [VW-1:0] exp_q [$];
    logic [31:0]   exp_addr = 32'd0;
    int            wr_count = 0;
    int            tile_count = 0;
    bit            busy_prev = 1'b0;
    bit            tile_prev = 1'b0;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] relu_model(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
`ifdef CONV_OUTPUT_WRITER_RELU_EN
        for (int k = 0; k < LANES; k++) begin
            if (v[k*16+15]) r[k*16 +: 16] = 16'h0000;
        end
`endif
        return r;
    endfunction

    // Output side of the scoreboard: every write pops one expected vector.
    always @(posedge clk) begin
        busy_prev = bram_busy;
        #1;
        if (!rst_n) begin
            exp_addr  = 32'd0;
            tile_prev = 1'b0;
        end else begin
            if (tile_prev) chk("bubble_after_tile", write_en, 1'b0);
            if (write_en) begin
                chk("write_while_busy", busy_prev, 1'b0);
                if (exp_q.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
                else chk("wr_data", output_pixels, exp_q.pop_front());
                chk("wr_addr", bram_wr_addr, exp_addr);
                chk("tile_done", tile_done, exp_addr == LAST);
                exp_addr = (exp_addr == LAST) ? 32'd0 : exp_addr + 32'd4;
                wr_count++;
            end else begin
                chk("tile_done_no_write", tile_done, 1'b0);
            end
            if (tile_done) tile_count++;
            tile_prev = tile_done;
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_write_en"}, write_en, 1'b0);
        chk({tag, "_addr"}, bram_wr_addr, 32'd0);
        chk({tag, "_pixels"}, output_pixels, '0);
        chk({tag, "_tile_done"}, tile_done, 1'b0);
        chk({tag, "_overflow"}, overflow, 1'b0);
        chk({tag, "_fill"}, fill_level, 3'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Producer honouring in_ready; called and returns on a falling edge.
    task automatic send(input logic [VW-1:0] v);
        int t = 0;
        while (!in_ready && t < 100) begin
            in_valid = 1'b0;
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("ready_timeout", 1'b0, 1'b1);
        in_valid  = 1'b1;
        in_pixels = v;
        exp_q.push_back(relu_model(v));
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || fill_level != 3'd0 || write_en) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", t < 200, 1'b1);
    endtask

    initial begin
        int base;
        int tbase;
        int sent;
        logic [VW-1:0] v1;
        logic [VW-1:0] vr;

        v1 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
        vr = 128'h0001_0002_0003_0004_0005_7FFF_8000_FFFF;

        repeat (2) @(negedge clk);
        chk_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Single vector: latency and single write pulse.
        in_valid  = 1'b1;
        in_pixels = v1;
        exp_q.push_back(relu_model(v1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_edge_n", write_en, 1'b0);
        @(negedge clk);
        chk("lat_edge_n1", write_en, 1'b0);
        @(negedge clk);
        chk("lat_edge_n2", write_en, 1'b1);
        chk("lat_addr", bram_wr_addr, 32'd0);
        @(negedge clk);
        chk("single_pulse", write_en, 1'b0);
        chk("single_fill", fill_level, 3'd0);

        // Fill while stalled: two drops, then ordered drain.
        do_reset();
        base = wr_count;
        bram_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'b1;
            in_pixels = {LANES{16'(i + 16'h10)}};
            if (i < 4) exp_q.push_back(relu_model(in_pixels));
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_overflow", overflow, 1'b1);
        chk("full_fill", fill_level, 3'd4);
        repeat (4) @(negedge clk);
        chk("busy_no_write", wr_count - base, 0);
        bram_busy = 1'b0;
        wait_drain();
        chk("full_drain_writes", wr_count - base, 4);
        chk("overflow_sticky", overflow, 1'b1);

        // Full tile plus one word: wrap to address 0 after the bubble.
        do_reset();
        base  = wr_count;
        tbase = tile_count;
        for (int i = 0; i < 2049; i++) send({LANES{16'(i)}});
        in_valid = 1'b0;
        wait_drain();
        chk("tile_writes", wr_count - base, 2049);
        chk("tile_pulses", tile_count - tbase, 1);
        chk("tile_last_addr", bram_wr_addr, 32'd0);

        // Alternating stall with a ready-respecting stream.
        base = wr_count;
        sent = 0;
        for (int i = 0; i < 40; i++) begin
            bram_busy = ~bram_busy;
            if (in_ready && sent < 20) begin
                in_valid  = 1'b1;
                in_pixels = {LANES{16'(16'h0100 + sent)}};
                exp_q.push_back(relu_model(in_pixels));
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        bram_busy = 1'b0;
        wait_drain();
        chk("alt_writes", wr_count - base, sent);
        chk("alt_no_drop", overflow, 1'b0);

        // Asynchronous reset with buffered data mid-tile.
        do_reset();
        for (int i = 0; i < 65; i++) send({LANES{16'(16'h0200 + i)}});
        in_valid = 1'b0;
        wait_drain();
        chk("pre_reset_addr", bram_wr_addr, 32'h100);
        bram_busy = 1'b1;
        for (int i = 0; i < 3; i++) send({LANES{16'(16'h0300 + i)}});
        in_valid = 1'b0;
        chk("pre_reset_fill", fill_level, 3'd3);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_values("async_rst");
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        bram_busy = 1'b0;
        @(negedge clk);
        base = wr_count;
        send(v1);
        in_valid = 1'b0;
        wait_drain();
        chk("post_reset_writes", wr_count - base, 1);
        chk("post_reset_addr", bram_wr_addr, 32'd0);

        // Lane sign handling.
        send(vr);
        in_valid = 1'b0;
        wait_drain();
`ifdef CONV_OUTPUT_WRITER_RELU_EN
        chk("relu_lanes", output_pixels[47:0], 48'h7FFF_0000_0000);
`else
        chk("relu_lanes", output_pixels[47:0], 48'h7FFF_8000_FFFF);
`endif
        chk("relu_addr", bram_wr_addr, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
